ula_control_md: RTL and testbench

- Parametrised, registered successor to the combinational ULA control decoder.
- Decodes ula_op plus {funct7,funct3} into a widened ULA select code and adds RV32M operation decoding.
- Sequences multi-cycle MUL/DIV operations with a start pulse and a latency counter.
- Valid/ready handshakes on both sides; sits between the decode stage and the execute stage / iterative M unit.

---
 rtl/ula_control_md.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ula_control_md.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_control_md.sv
`default_nettype none
// ============================================================================
//  Module   : ula_control_md
//  Purpose  : Registered ULA control decoder with RV32M decode and MUL/DIV
//             launch sequencing. Sits between the decode stage and the
//             execute stage / iterative M unit, valid/ready on both sides.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             flush           - drop any in-flight or held operation
//             in_valid/ready  - decode-side handshake (ula_op, inst)
//             inst            - {funct7[6:0], funct3[2:0]}
//             ula_op          - operation class from main control
//             out_valid/ready - execute-side handshake
//             ula_select      - registered select code (zero-extended)
//             illegal         - registered, high when the select code is 0
//             md_start        - one-cycle launch pulse for the M unit
//             md_busy         - M operation in flight
//             md_kill         - flush hit an in-flight M operation
//  Macro    : ULA_CTRL_M_EXT_EN enables RV32M decode and MD_WAIT sequencing.
//             Undefined: md_* outputs are tied 0 and codes 13..20 never occur.
//  Revision : 1.0 - initial release
// ============================================================================
module ula_control_md #(
    parameter int SEL_W   = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [9:0]       inst,
    input  logic [2:0]       ula_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] ula_select,
    output logic             illegal,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_kill
);

`ifdef ULA_CTRL_M_EXT_EN
    localparam logic c_M_EN = 1'b1;
`else
    localparam logic c_M_EN = 1'b0;
`endif

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    // State encoding
    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_MD_WAIT = 2'd1;
    localparam logic [1:0] c_S_HOLD    = 2'd2;

    // Select codes
    localparam logic [4:0] c_NONE  = 5'd0;
    localparam logic [4:0] c_ADD   = 5'd1;
    localparam logic [4:0] c_SUB   = 5'd2;
    localparam logic [4:0] c_SLL   = 5'd3;
    localparam logic [4:0] c_SLT   = 5'd4;
    localparam logic [4:0] c_SLTU  = 5'd5;
    localparam logic [4:0] c_SRL   = 5'd6;
    localparam logic [4:0] c_SRA   = 5'd7;
    localparam logic [4:0] c_XOR   = 5'd8;
    localparam logic [4:0] c_OR    = 5'd9;
    localparam logic [4:0] c_AND   = 5'd10;
    localparam logic [4:0] c_LUI   = 5'd11;
    localparam logic [4:0] c_AUIPC = 5'd12;
    localparam logic [4:0] c_MUL   = 5'd13;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_M    = 7'b0000001;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic               r_out_valid;
    logic [SEL_W-1:0]   r_sel;
    logic               r_illegal;
    logic               r_md_start;
    logic               r_md_busy;
    logic               r_md_kill;
    logic [c_CNT_W-1:0] r_cnt;

    // Next-state values
    logic [1:0]         w_state_n;
    logic               w_out_valid_n;
    logic [SEL_W-1:0]   w_sel_n;
    logic               w_illegal_n;
    logic               w_md_start_n;
    logic               w_md_busy_n;
    logic               w_md_kill_n;
    logic [c_CNT_W-1:0] w_cnt_n;

    // Decode results
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [4:0] w_code;
    logic       w_is_m;
    logic       w_is_div;
    logic       w_in_ready;
    logic       w_accept;

    assign w_funct7 = inst[9:3];
    assign w_funct3 = inst[2:0];

    // ------------------------------------------------------------------
    // Combinational decoder
    // ------------------------------------------------------------------
    always_comb begin
        w_code   = c_NONE;
        w_is_m   = 1'b0;
        w_is_div = 1'b0;
        case (ula_op)
            3'b000: w_code = c_ADD;
            3'b001: w_code = c_SUB;
            3'b100: w_code = c_LUI;
            3'b101: w_code = c_AUIPC;
            3'b010, 3'b011: begin
                case (w_funct3)
                    // I-type has no SUB form; funct3 000 is always ADD there
                    3'b000:  w_code = ((ula_op == 3'b010) && (w_funct7 == c_F7_ALT)) ? c_SUB : c_ADD;
                    3'b001:  w_code = c_SLL;
                    3'b010:  w_code = c_SLT;
                    3'b011:  w_code = c_SLTU;
                    3'b100:  w_code = c_XOR;
                    3'b101: begin
                        if (w_funct7 == c_F7_BASE) begin
                            w_code = c_SRL;
                        end else if (w_funct7 == c_F7_ALT) begin
                            w_code = c_SRA;
                        end else begin
                            w_code = c_NONE;
                        end
                    end
                    3'b110:  w_code = c_OR;
                    default: w_code = c_AND;
                endcase
                // RV32M overrides the base R-type rules; funct3 indexes 13..20
                if (c_M_EN && (ula_op == 3'b010) && (w_funct7 == c_F7_M)) begin
                    w_code   = c_MUL + {2'b00, w_funct3};
                    w_is_m   = 1'b1;
                    w_is_div = w_funct3[2];
                end
            end
            default: w_code = c_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_in_ready = (r_state == c_S_IDLE) && (!r_out_valid || out_ready) && !flush;
    assign w_accept   = in_valid && w_in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_out_valid_n = r_out_valid;
        w_sel_n       = r_sel;
        w_illegal_n   = r_illegal;
        w_md_start_n  = 1'b0;
        w_md_busy_n   = r_md_busy;
        w_md_kill_n   = 1'b0;
        w_cnt_n       = r_cnt;

        if (flush) begin
            w_state_n     = c_S_IDLE;
            w_out_valid_n = 1'b0;
            w_md_busy_n   = 1'b0;
            w_md_kill_n   = r_md_busy;
            w_cnt_n       = '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (r_out_valid) begin
                        if (out_ready) begin
                            w_out_valid_n = 1'b0;
                        end else begin
                            w_state_n = c_S_HOLD;
                        end
                    end
                    if (w_accept) begin
                        w_sel_n     = SEL_W'(w_code);
                        w_illegal_n = (w_code == c_NONE);
                        if (w_is_m) begin
                            // Result is withheld until the M unit latency expires
                            w_state_n     = c_S_MD_WAIT;
                            w_out_valid_n = 1'b0;
                            w_md_start_n  = 1'b1;
                            w_md_busy_n   = 1'b1;
                            w_cnt_n       = w_is_div ? c_CNT_W'(DIV_LAT) : c_CNT_W'(MUL_LAT);
                        end else begin
                            w_out_valid_n = 1'b1;
                        end
                    end
                end
                c_S_MD_WAIT: begin
                    // Counter was loaded with LAT on entry; the last busy
                    // cycle is the one that sees 1.
                    if (r_cnt <= c_CNT_W'(1)) begin
                        w_state_n     = c_S_HOLD;
                        w_out_valid_n = 1'b1;
                        w_md_busy_n   = 1'b0;
                        w_cnt_n       = '0;
                    end else begin
                        w_cnt_n = r_cnt - c_CNT_W'(1);
                    end
                end
                c_S_HOLD: begin
                    if (out_ready) begin
                        w_state_n     = c_S_IDLE;
                        w_out_valid_n = 1'b0;
                    end
                end
                default: begin
                    w_state_n     = c_S_IDLE;
                    w_out_valid_n = 1'b0;
                    w_md_busy_n   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_out_valid <= 1'b0;
            r_sel       <= '0;
            r_illegal   <= 1'b0;
            r_md_start  <= 1'b0;
            r_md_busy   <= 1'b0;
            r_md_kill   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_out_valid <= w_out_valid_n;
            r_sel       <= w_sel_n;
            r_illegal   <= w_illegal_n;
            r_md_start  <= w_md_start_n;
            r_md_busy   <= w_md_busy_n;
            r_md_kill   <= w_md_kill_n;
            r_cnt       <= w_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign ula_select = r_sel;
    assign illegal    = r_illegal;
    // Without the M extension these collapse to constant 0
    assign md_start   = r_md_start & c_M_EN;
    assign md_busy    = r_md_busy  & c_M_EN;
    assign md_kill    = r_md_kill  & c_M_EN;

endmodule
`default_nettype wire

// File: tb/tb_ula_control_md.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ula_control_md
//  Purpose  : Scoreboard bench for ula_control_md. Expected select codes are
//             queued on accept; a negedge monitor pops and compares on every
//             out_valid & out_ready. M-extension checks follow the
//             ULA_CTRL_M_EXT_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ula_control_md;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] inst;
    logic [2:0] ula_op;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] ula_select;
    logic       illegal;
    logic       md_start;
    logic       md_busy;
    logic       md_kill;

    ula_control_md #(
        .SEL_W  (5),
        .MUL_LAT(2),
        .DIV_LAT(33)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .ula_op    (ula_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ula_select(ula_select),
        .illegal   (illegal),
        .md_start  (md_start),
        .md_busy   (md_busy),
        .md_kill   (md_kill)
    );

`ifdef ULA_CTRL_M_EXT_EN
    localparam int c_EXP_MUL   = 13;
    localparam int c_EXP_DIVU  = 18;
    localparam int c_EXP_REMU  = 20;
    localparam int c_EXP_START = 2;
    localparam int c_EXP_KILL  = 1;
`else
    localparam int c_EXP_MUL   = 1;
    localparam int c_EXP_DIVU  = 0;
    localparam int c_EXP_REMU  = 10;
    localparam int c_EXP_START = 0;
    localparam int c_EXP_KILL  = 0;
`endif

    typedef struct packed {
        logic [4:0] sel;
        logic       ill;
    } exp_t;

    exp_t q[$];
    exp_t r_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   starts   = 0;
    int   kills    = 0;
    logic r_prev_stall = 1'b0;
    logic [4:0] r_prev_sel = '0;
    logic       r_prev_ill = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && md_start) starts <= starts + 1;
        if (!rst && md_kill)  kills  <= kills + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: hold stability and scoreboard pop on each output handshake
    always @(negedge clk) begin
        if (rst) begin
            r_prev_stall = 1'b0;
        end else begin
            if (r_prev_stall && out_valid) begin
                chk("hold_sel_stable", ula_select, r_prev_sel);
                chk("hold_ill_stable", illegal, r_prev_ill);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    r_e = q.pop_front();
                    chk("sb_select", ula_select, r_e.sel);
                    chk("sb_illegal", illegal, r_e.ill);
                end
            end
            r_prev_stall = out_valid && !out_ready;
            r_prev_sel   = ula_select;
            r_prev_ill   = illegal;
        end
    end

    // Presents one operation and returns #1 after the accepting edge
    task automatic send(input logic [2:0] op, input logic [9:0] ins,
                        input int esel, input logic eill, input bit expect_out);
        int n;
        n        = 0;
        ula_op   = op;
        inst     = ins;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("accept", in_ready, 1);
        if (in_ready && expect_out) q.push_back('{sel: 5'(esel), ill: eill});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int ov;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = '0;
        ula_op    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_select", ula_select, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_kill", md_kill, 0);
        chk("rst_in_ready", in_ready, 1);

        // Decode table, back-to-back with out_ready high
        @(posedge clk);
        #1 out_ready = 1'b1;
        c0 = cyc;
        send(3'b010, {7'b0100000, 3'b000}, 2, 1'b0, 1);
        send(3'b010, {7'b0000000, 3'b101}, 6, 1'b0, 1);
        send(3'b010, {7'b0100000, 3'b101}, 7, 1'b0, 1);
        send(3'b010, {7'b0000010, 3'b101}, 0, 1'b1, 1);
        chk("throughput_cycles", cyc - c0, 4);
        send(3'b000, 10'h3ff,               1,  1'b0, 1);
        send(3'b001, 10'h000,               2,  1'b0, 1);
        send(3'b100, 10'h000,               11, 1'b0, 1);
        send(3'b101, 10'h155,               12, 1'b0, 1);
        send(3'b110, 10'h000,               0,  1'b1, 1);
        send(3'b111, 10'h000,               0,  1'b1, 1);
        send(3'b011, {7'b0100000, 3'b000}, 1,  1'b0, 1);
        send(3'b011, {7'b0100000, 3'b101}, 7,  1'b0, 1);
        send(3'b011, {7'b0000001, 3'b000}, 1,  1'b0, 1);
        send(3'b010, {7'b0000000, 3'b001}, 3,  1'b0, 1);
        send(3'b010, {7'b0000000, 3'b010}, 4,  1'b0, 1);
        send(3'b010, {7'b1111111, 3'b011}, 5,  1'b0, 1);
        send(3'b010, {7'b0000000, 3'b100}, 8,  1'b0, 1);
        send(3'b010, {7'b0000000, 3'b110}, 9,  1'b0, 1);
        send(3'b010, {7'b1111111, 3'b111}, 10, 1'b0, 1);
`ifndef ULA_CTRL_M_EXT_EN
        // M-encoded funct7 falls through to base R-type rules
        send(3'b010, {7'b0000001, 3'b000}, c_EXP_MUL,  1'b0, 1);
        send(3'b010, {7'b0000001, 3'b101}, c_EXP_DIVU, 1'b1, 1);
        send(3'b010, {7'b0000001, 3'b111}, c_EXP_REMU, 1'b0, 1);
`endif
        repeat (2) @(negedge clk);

        // Backpressure: ADD held for 3 cycles, then SUB and XOR in order
        @(posedge clk);
        #1;
        send(3'b000, 10'h000, 1, 1'b0, 1);
        out_ready = 1'b0;
        fork
            send(3'b001, 10'h000, 2, 1'b0, 1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_select", ula_select, 1);
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        send(3'b010, {7'b0000000, 3'b100}, 8, 1'b0, 1);
        repeat (3) @(negedge clk);

        // Flush discards a held result
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(3'b000, 10'h000, 1, 1'b0, 0);
        @(negedge clk);
        chk("held_out_valid", out_valid, 1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_hold_out_valid", out_valid, 0);
        chk("flush_hold_md_kill", md_kill, 0);
        chk("flush_hold_in_ready", in_ready, 1);
        out_ready = 1'b1;

`ifdef ULA_CTRL_M_EXT_EN
        // MUL, latency 2
        @(posedge clk);
        #1;
        send(3'b010, {7'b0000001, 3'b000}, 13, 1'b0, 1);
        @(negedge clk);
        chk("mul_c1_start", md_start, 1);
        chk("mul_c1_busy", md_busy, 1);
        chk("mul_c1_in_ready", in_ready, 0);
        chk("mul_c1_out_valid", out_valid, 0);
        @(negedge clk);
        chk("mul_c2_start", md_start, 0);
        chk("mul_c2_busy", md_busy, 1);
        chk("mul_c2_in_ready", in_ready, 0);
        chk("mul_c2_out_valid", out_valid, 0);
        @(negedge clk);
        chk("mul_c3_out_valid", out_valid, 1);
        chk("mul_c3_busy", md_busy, 0);
        chk("mul_c3_in_ready", in_ready, 0);
        @(negedge clk);
        chk("mul_c4_in_ready", in_ready, 1);
        chk("mul_c4_out_valid", out_valid, 0);

        // DIV killed by flush at cycle 10
        @(posedge clk);
        #1;
        send(3'b010, {7'b0000001, 3'b100}, 17, 1'b0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        ula_op   = 3'b000;
        inst     = 10'h000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("div_c10_busy", md_busy, 1);
        chk("div_c10_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("div_c11_kill", md_kill, 1);
        chk("div_c11_busy", md_busy, 0);
        chk("div_c11_in_ready", in_ready, 1);
        chk("div_c11_out_valid", out_valid, 0);
        @(negedge clk);
        chk("div_c12_kill", md_kill, 0);
        ov = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        chk("div_flushed_no_output", ov, 0);
`endif

        repeat (3) @(negedge clk);
        chk("md_start_pulses", starts, c_EXP_START);
        chk("md_kill_pulses", kills, c_EXP_KILL);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
